// File: rtl/bit_run_profiler.sv
`default_nettype none
// ============================================================================
//  Module      : bit_run_profiler
//  Description : Counts blocks of consecutive target bits (runs of length
//                >= MIN_RUN) across a packet of one or more words, and reports
//                the longest target run. Runs may span word boundaries and
//                idle (data_enb=0) cycles. The target bit (1 or 0) is chosen
//                per packet by polarity, which is sampled on the first word.
//                One result is emitted per packet, two cycles after the word
//                flagged last.
//  Ports       : clk       - clock, all logic on rising edge
//                rst       - synchronous active-high reset
//                data      - input word, bit 0 scanned first
//                data_enb  - word qualifier
//                last      - word closes the current packet
//                polarity  - 0: runs of 1s, 1: runs of 0s (first word only)
//                block_cnt - blocks in completed packet (saturating)
//                max_run   - longest target run in packet (saturating)
//                sat       - block_cnt or max_run saturated in this packet
//                valid     - one-cycle result strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_run_profiler #(
  parameter int DATA_W  = 32,
  parameter int MIN_RUN = 2,
  parameter int CNT_W   = 8,
  parameter int RUN_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              data_enb,
  input  logic              last,
  input  logic              polarity,
  output logic [CNT_W-1:0]  block_cnt,
  output logic [RUN_W-1:0]  max_run,
  output logic              sat,
  output logic              valid
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [RUN_W-1:0] c_RUN_MAX = '1;

  // Packet-framing FSM lives on the input side so that the polarity applied
  // in S1 is already known for the word being sampled.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_pol;
  logic   w_pol;

  // S1 registers
  logic [DATA_W-1:0] r_s1_data;
  logic              r_s1_enb;
  logic              r_s1_last;

  // S2 accumulator
  logic [RUN_W-1:0]  r_carry;
  logic [RUN_W-1:0]  r_acc_max;
  logic [CNT_W-1:0]  r_acc_cnt;
  logic              r_acc_sat;

  // S2 result staging
  logic [CNT_W-1:0]  r_res_cnt;
  logic [RUN_W-1:0]  r_res_max;
  logic              r_res_sat;
  logic              r_s2_emit;

  // Output registers
  logic [CNT_W-1:0]  r_block_cnt;
  logic [RUN_W-1:0]  r_max_run;
  logic              r_sat;
  logic              r_valid;

  // Scan results
  logic [RUN_W-1:0]  w_run;
  logic [RUN_W-1:0]  w_max;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_sat;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pol       = r_pol;
    case (r_state)
      IDLE: begin
        // First word of a packet takes the live polarity input.
        w_pol = polarity;
        if (data_enb && !last) begin
          w_state_nxt = IN_PKT;
        end
      end
      IN_PKT: begin
        if (data_enb && last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // S1: normalise so that the target bit is always 1
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_data <= '0;
      r_s1_enb  <= 1'b0;
      r_s1_last <= 1'b0;
      r_pol     <= 1'b0;
    end else begin
      r_s1_enb  <= data_enb;
      r_s1_last <= data_enb & last;
      if (data_enb) begin
        r_s1_data <= data ^ {DATA_W{w_pol}};
        r_pol     <= w_pol;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S2 scan: walk bits LSB first, continuing the run carried from the
  // previous word of the packet.
  // --------------------------------------------------------------------------
  always_comb begin
    w_run = r_carry;
    w_max = r_acc_max;
    w_cnt = r_acc_cnt;
    w_sat = r_acc_sat;
    for (int i = 0; i < DATA_W; i++) begin
      if (r_s1_data[i]) begin
        if (w_run == c_RUN_MAX) begin
          w_sat = 1'b1;
        end else begin
          w_run = w_run + 1'b1;
          // Counting only on the increment that lands exactly on MIN_RUN
          // guarantees one count per block, even across word boundaries.
          if (32'(w_run) == MIN_RUN) begin
            if (w_cnt == c_CNT_MAX) begin
              w_sat = 1'b1;
            end else begin
              w_cnt = w_cnt + 1'b1;
            end
          end
        end
      end else begin
        w_run = '0;
      end
      if (w_run > w_max) begin
        w_max = w_run;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry   <= '0;
      r_acc_max <= '0;
      r_acc_cnt <= '0;
      r_acc_sat <= 1'b0;
      r_res_cnt <= '0;
      r_res_max <= '0;
      r_res_sat <= 1'b0;
      r_s2_emit <= 1'b0;
    end else begin
      r_s2_emit <= 1'b0;
      if (r_s1_enb) begin
        if (r_s1_last) begin
          // Close the packet and clear in the same cycle so a following
          // word starts a fresh packet with no carried run.
          r_res_cnt <= w_cnt;
          r_res_max <= w_max;
          r_res_sat <= w_sat;
          r_s2_emit <= 1'b1;
          r_carry   <= '0;
          r_acc_max <= '0;
          r_acc_cnt <= '0;
          r_acc_sat <= 1'b0;
        end else begin
          r_carry   <= w_run;
          r_acc_max <= w_max;
          r_acc_cnt <= w_cnt;
          r_acc_sat <= w_sat;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output registers: hold until the next emit
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_block_cnt <= '0;
      r_max_run   <= '0;
      r_sat       <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= r_s2_emit;
      if (r_s2_emit) begin
        r_block_cnt <= r_res_cnt;
        r_max_run   <= r_res_max;
        r_sat       <= r_res_sat;
      end
    end
  end

  assign block_cnt = r_block_cnt;
  assign max_run   = r_max_run;
  assign sat       = r_sat;
  assign valid     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_bit_run_profiler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_run_profiler
//  Description : Directed self-checking bench for bit_run_profiler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_run_profiler;

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic        data_enb;
  logic        last;
  logic        polarity;
  logic [7:0]  block_cnt;
  logic [7:0]  max_run;
  logic        sat;
  logic        valid;

  int n_cmp;
  int n_bad;
  int cyc;

  // Results captured by the monitor
  logic [7:0] q_cnt[$];
  logic [7:0] q_max[$];
  logic       q_sat[$];
  int         q_cyc[$];

  bit_run_profiler #(
    .DATA_W(32), .MIN_RUN(2), .CNT_W(8), .RUN_W(8)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .data_enb(data_enb), .last(last),
    .polarity(polarity), .block_cnt(block_cnt), .max_run(max_run),
    .sat(sat), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      q_cnt.push_back(block_cnt);
      q_max.push_back(max_run);
      q_sat.push_back(sat);
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_q();
    q_cnt.delete(); q_max.delete(); q_sat.delete(); q_cyc.delete();
  endtask

  // Drive one word so that it is sampled on the next rising edge.
  task automatic drive(input logic [31:0] d, input logic l, input logic p);
    @(negedge clk);
    data = d; last = l; polarity = p; data_enb = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_enb = 1'b0; last = 1'b0; data = 32'h0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_cmp++; if (block_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", block_cnt); end
    n_cmp++; if (max_run !== 8'd0) begin n_bad++; $display("FAIL reset_max got=%0d exp=0", max_run); end
    n_cmp++; if (sat !== 1'b0) begin n_bad++; $display("FAIL reset_sat got=%b exp=0", sat); end
  endtask

  task automatic test_basic();
    int t;
    clear_q();
    @(negedge clk);
    t = cyc;
    data = 32'h0000_0F0F; last = 1'b1; polarity = 1'b0; data_enb = 1'b1;
    idle(5);
    n_cmp++; if (q_cnt.size() !== 1) begin n_bad++; $display("FAIL basic_nvalid got=%0d exp=1", q_cnt.size()); end
    if (q_cnt.size() >= 1) begin
      n_cmp++; if (q_cyc[0] !== t + 3) begin n_bad++; $display("FAIL basic_latency got=%0d exp=%0d", q_cyc[0] - t - 1, 2); end
      n_cmp++; if (q_cnt[0] !== 8'd2) begin n_bad++; $display("FAIL basic_cnt got=%0d exp=2", q_cnt[0]); end
      n_cmp++; if (q_max[0] !== 8'd4) begin n_bad++; $display("FAIL basic_max got=%0d exp=4", q_max[0]); end
      n_cmp++; if (q_sat[0] !== 1'b0) begin n_bad++; $display("FAIL basic_sat got=%b exp=0", q_sat[0]); end
    end
    // Outputs hold after the pulse
    n_cmp++; if (block_cnt !== 8'd2 || valid !== 1'b0) begin n_bad++; $display("FAIL basic_hold got=%0d/%b exp=2/0", block_cnt, valid); end
  endtask

  task automatic test_polarity();
    clear_q();
    drive(32'h0000_0001, 1'b1, 1'b1);
    idle(1);
    drive(32'h5555_5555, 1'b1, 1'b0);
    idle(5);
    n_cmp++; if (q_cnt.size() !== 2) begin n_bad++; $display("FAIL pol_nvalid got=%0d exp=2", q_cnt.size()); end
    if (q_cnt.size() >= 2) begin
      n_cmp++; if (q_cnt[0] !== 8'd1) begin n_bad++; $display("FAIL pol1_cnt got=%0d exp=1", q_cnt[0]); end
      n_cmp++; if (q_max[0] !== 8'd31) begin n_bad++; $display("FAIL pol1_max got=%0d exp=31", q_max[0]); end
      n_cmp++; if (q_cnt[1] !== 8'd0) begin n_bad++; $display("FAIL pol0_cnt got=%0d exp=0", q_cnt[1]); end
      n_cmp++; if (q_max[1] !== 8'd1) begin n_bad++; $display("FAIL pol0_max got=%0d exp=1", q_max[1]); end
    end
  endtask

  task automatic test_span();
    clear_q();
    drive(32'hC000_0000, 1'b0, 1'b0);
    idle(3);
    // Polarity flip mid-packet must be ignored
    drive(32'h0000_0001, 1'b1, 1'b1);
    idle(5);
    n_cmp++; if (q_cnt.size() !== 1) begin n_bad++; $display("FAIL span_nvalid got=%0d exp=1", q_cnt.size()); end
    if (q_cnt.size() >= 1) begin
      n_cmp++; if (q_cnt[0] !== 8'd1) begin n_bad++; $display("FAIL span_cnt got=%0d exp=1", q_cnt[0]); end
      n_cmp++; if (q_max[0] !== 8'd3) begin n_bad++; $display("FAIL span_max got=%0d exp=3", q_max[0]); end
    end
  endtask

  task automatic test_saturation();
    clear_q();
    for (int i = 0; i < 32; i++) begin
      drive(32'h3333_3333, (i == 31), 1'b0);
    end
    idle(5);
    n_cmp++; if (q_cnt.size() !== 1) begin n_bad++; $display("FAIL sat_nvalid got=%0d exp=1", q_cnt.size()); end
    if (q_cnt.size() >= 1) begin
      n_cmp++; if (q_cnt[0] !== 8'd255) begin n_bad++; $display("FAIL sat_cnt got=%0d exp=255", q_cnt[0]); end
      n_cmp++; if (q_max[0] !== 8'd2) begin n_bad++; $display("FAIL sat_max got=%0d exp=2", q_max[0]); end
      n_cmp++; if (q_sat[0] !== 1'b1) begin n_bad++; $display("FAIL sat_flag got=%b exp=1", q_sat[0]); end
    end
    // Exactly 255 blocks: at the limit, nothing lost
    clear_q();
    for (int i = 0; i < 32; i++) begin
      drive((i == 31) ? 32'h0333_3333 : 32'h3333_3333, (i == 31), 1'b0);
    end
    idle(5);
    n_cmp++; if (q_cnt.size() !== 1) begin n_bad++; $display("FAIL sat255_nvalid got=%0d exp=1", q_cnt.size()); end
    if (q_cnt.size() >= 1) begin
      n_cmp++; if (q_cnt[0] !== 8'd255) begin n_bad++; $display("FAIL sat255_cnt got=%0d exp=255", q_cnt[0]); end
      n_cmp++; if (q_sat[0] !== 1'b0) begin n_bad++; $display("FAIL sat255_flag got=%b exp=0", q_sat[0]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    drive(32'hFFFF_FFFF, 1'b1, 1'b0);
    drive(32'h0000_0000, 1'b1, 1'b0);
    idle(5);
    n_cmp++; if (q_cnt.size() !== 2) begin n_bad++; $display("FAIL b2b_nvalid got=%0d exp=2", q_cnt.size()); end
    if (q_cnt.size() >= 2) begin
      n_cmp++; if (q_cyc[1] !== q_cyc[0] + 1) begin n_bad++; $display("FAIL b2b_consec got=%0d exp=1", q_cyc[1] - q_cyc[0]); end
      n_cmp++; if (q_cnt[0] !== 8'd1 || q_max[0] !== 8'd32) begin n_bad++; $display("FAIL b2b_first got=%0d,%0d exp=1,32", q_cnt[0], q_max[0]); end
      n_cmp++; if (q_cnt[1] !== 8'd0 || q_max[1] !== 8'd0) begin n_bad++; $display("FAIL b2b_second got=%0d,%0d exp=0,0", q_cnt[1], q_max[1]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    drive(32'h8000_0000, 1'b0, 1'b0);
    @(negedge clk);
    data_enb = 1'b0; last = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(32'h0000_0001, 1'b1, 1'b0);
    idle(5);
    n_cmp++; if (q_cnt.size() !== 1) begin n_bad++; $display("FAIL rstmid_nvalid got=%0d exp=1", q_cnt.size()); end
    if (q_cnt.size() >= 1) begin
      n_cmp++; if (q_cnt[0] !== 8'd0) begin n_bad++; $display("FAIL rstmid_cnt got=%0d exp=0", q_cnt[0]); end
      n_cmp++; if (q_max[0] !== 8'd1) begin n_bad++; $display("FAIL rstmid_max got=%0d exp=1", q_max[0]); end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst = 1'b1; data = '0; data_enb = 1'b0; last = 1'b0; polarity = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    idle(2);
    test_basic();
    test_polarity();
    test_span();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
